// File: rtl/cipher_output_collector.sv
`default_nettype none
// ============================================================================
// Module   : cipher_output_collector
// Purpose  : Gathers four two-share ciphertext words after done rises and
//            presents them as one 128-bit block on a buffered valid/ready port.
// Revision : 1.0
// ============================================================================
module cipher_output_collector #(
    parameter int WORDS = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         OutputData0,
    input  logic [31:0]         OutputData1,
    input  logic                done,
    output logic [127:0]        ct_share0,
    output logic [127:0]        ct_share1,
    output logic [127:0]        ct_data,
    output logic                ct_valid,
    input  logic                ct_ready,
    output logic                overflow,
    output logic                frame_err,
    output logic [CNT_W-1:0]    drop_cnt
);

    localparam int         c_BLK_W = 32 * WORDS;
    localparam int         c_CAP_W = 32 * (WORDS - 1);
    localparam logic [1:0] c_LAST  = 2'(WORDS - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t               r_state_q, w_state_d;
    logic [1:0]           r_cnt_q,   w_cnt_d;
    logic                 r_done_q,  w_done_d;
    logic [c_CAP_W-1:0]   r_cap0_q,  w_cap0_d;
    logic [c_CAP_W-1:0]   r_cap1_q,  w_cap1_d;
    logic [c_BLK_W-1:0]   r_sh0_q,   w_sh0_d;
    logic [c_BLK_W-1:0]   r_sh1_q,   w_sh1_d;
    logic [c_BLK_W-1:0]   r_data_q,  w_data_d;
    logic                 r_valid_q, w_valid_d;
    logic                 r_ovf_q,   w_ovf_d;
    logic                 r_ferr_q,  w_ferr_d;
    logic [CNT_W-1:0]     r_drop_q,  w_drop_d;

    logic                 w_rise;
    logic                 w_complete;
    logic [c_BLK_W-1:0]   w_blk0;
    logic [c_BLK_W-1:0]   w_blk1;

    assign w_rise = done && !r_done_q;
    // The last word bypasses the capture buffer straight into the output stage.
    assign w_blk0 = {r_cap0_q, OutputData0};
    assign w_blk1 = {r_cap1_q, OutputData1};

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_done_d   = done;
        w_cap0_d   = r_cap0_q;
        w_cap1_d   = r_cap1_q;
        w_ferr_d   = r_ferr_q;
        w_complete = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    w_cap0_d[c_CAP_W-1 -: 32] = OutputData0;
                    w_cap1_d[c_CAP_W-1 -: 32] = OutputData1;
                    w_cnt_d   = 2'd1;
                    w_state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_rise) begin
                    // A fresh done edge mid-block wins: restart with this word 0.
                    w_ferr_d = 1'b1;
                    w_cap0_d[c_CAP_W-1 -: 32] = OutputData0;
                    w_cap1_d[c_CAP_W-1 -: 32] = OutputData1;
                    w_cnt_d  = 2'd1;
                end else if (r_cnt_q == c_LAST) begin
                    w_complete = 1'b1;
                    w_cnt_d    = 2'd0;
                    w_state_d  = ST_IDLE;
                end else begin
                    case (r_cnt_q)
                        2'd1: begin
                            w_cap0_d[63:32] = OutputData0;
                            w_cap1_d[63:32] = OutputData1;
                        end
                        2'd2: begin
                            w_cap0_d[31:0] = OutputData0;
                            w_cap1_d[31:0] = OutputData1;
                        end
                        default: begin
                            w_cap0_d = r_cap0_q;
                            w_cap1_d = r_cap1_q;
                        end
                    endcase
                    w_cnt_d = r_cnt_q + 2'd1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        w_sh0_d   = r_sh0_q;
        w_sh1_d   = r_sh1_q;
        w_data_d  = r_data_q;
        w_valid_d = r_valid_q;
        w_ovf_d   = r_ovf_q;
        w_drop_d  = r_drop_q;

        if (w_complete) begin
            if (!r_valid_q || ct_ready) begin
                w_sh0_d   = w_blk0;
                w_sh1_d   = w_blk1;
                w_data_d  = w_blk0 ^ w_blk1;
                w_valid_d = 1'b1;
            end else begin
                w_ovf_d = 1'b1;
                if (r_drop_q != {CNT_W{1'b1}}) begin
                    w_drop_d = r_drop_q + 1'b1;
                end
            end
        end else if (r_valid_q && ct_ready) begin
            w_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= 2'd0;
            // Starts high so a done already asserted at reset release is no edge.
            r_done_q  <= 1'b1;
            r_cap0_q  <= '0;
            r_cap1_q  <= '0;
            r_sh0_q   <= '0;
            r_sh1_q   <= '0;
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_ferr_q  <= 1'b0;
            r_drop_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_done_q  <= w_done_d;
            r_cap0_q  <= w_cap0_d;
            r_cap1_q  <= w_cap1_d;
            r_sh0_q   <= w_sh0_d;
            r_sh1_q   <= w_sh1_d;
            r_data_q  <= w_data_d;
            r_valid_q <= w_valid_d;
            r_ovf_q   <= w_ovf_d;
            r_ferr_q  <= w_ferr_d;
            r_drop_q  <= w_drop_d;
        end
    end

    assign ct_share0 = r_sh0_q;
    assign ct_share1 = r_sh1_q;
    assign ct_data   = r_data_q;
    assign ct_valid  = r_valid_q;
    assign overflow  = r_ovf_q;
    assign frame_err = r_ferr_q;
    assign drop_cnt  = r_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_cipher_output_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_cipher_output_collector
// Purpose  : Self-checking bench: block vectors, scoreboard, handshake corners.
// Revision : 1.0
// ============================================================================
module tb_cipher_output_collector;

    localparam int CNT_W = 8;

    logic               clk;
    logic               rst;
    logic [31:0]        OutputData0;
    logic [31:0]        OutputData1;
    logic               done;
    logic [127:0]       ct_share0;
    logic [127:0]       ct_share1;
    logic [127:0]       ct_data;
    logic               ct_valid;
    logic               ct_ready;
    logic               overflow;
    logic               frame_err;
    logic [CNT_W-1:0]   drop_cnt;

    cipher_output_collector #(.WORDS(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .OutputData0(OutputData0),
        .OutputData1(OutputData1),
        .done       (done),
        .ct_share0  (ct_share0),
        .ct_share1  (ct_share1),
        .ct_data    (ct_data),
        .ct_valid   (ct_valid),
        .ct_ready   (ct_ready),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] s0;
        logic [127:0] s1;
        logic [127:0] data;
    } blk_t;

    blk_t   vecs[4];
    blk_t   sb[$];
    blk_t   exp_blk;
    int     checks;
    int     errors;
    int     hs_count;
    int     hs_base;

    localparam logic [127:0] c_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_MASK = 128'ha5a5a5a55a5a5a5a12345678deadbeef;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        done = 1'b0;
        OutputData0 = '0;
        OutputData1 = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    // Drives one block, done high only with word 0; optionally pulses ready on word 3.
    task automatic send_block(input logic [127:0] s0, input logic [127:0] s1,
                              input bit chk_quiet, input bit pulse_last);
        for (int i = 0; i < 4; i++) begin
            done = (i == 0);
            OutputData0 = s0[127 - 32*i -: 32];
            OutputData1 = s1[127 - 32*i -: 32];
            if (pulse_last) ct_ready = (i == 3);
            if (chk_quiet) begin
                @(negedge clk);
                check("valid_before_T4", {127'd0, ct_valid}, 128'd0);
            end
            tick();
        end
        done = 1'b0;
        OutputData0 = '0;
        OutputData1 = '0;
        if (pulse_last) ct_ready = 1'b0;
    endtask

    // Scoreboard: every accepted block must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && ct_valid && ct_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_block: got data %h expected no block", ct_data);
            end else begin
                exp_blk = sb.pop_front();
                check("blk_share0", ct_share0, exp_blk.s0);
                check("blk_share1", ct_share1, exp_blk.s1);
                check("blk_data",   ct_data,   exp_blk.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        hs_count = 0;
        ct_ready = 1'b0;

        vecs[0] = '{c_CT, 128'h0, c_CT};
        vecs[1] = '{c_CT ^ c_MASK, c_MASK, c_CT};
        vecs[2] = '{{128{1'b1}}, {128{1'b1}}, 128'h0};
        vecs[3] = '{128'h0123456789abcdef0011223344556677,
                    128'hfedcba9876543210ffeeddccbbaa9988,
                    {128{1'b1}}};

        do_reset();
        @(negedge clk);
        check("rst_valid",    {127'd0, ct_valid},  128'd0);
        check("rst_overflow", {127'd0, overflow},  128'd0);
        check("rst_frame",    {127'd0, frame_err}, 128'd0);
        check("rst_drop",     {120'd0, drop_cnt},  128'd0);
        check("rst_data",     ct_data,   128'd0);
        check("rst_share0",   ct_share0, 128'd0);
        check("rst_share1",   ct_share1, 128'd0);
        tick();

        // Table vectors with the consumer always ready.
        ct_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(vecs[i]);
            send_block(vecs[i].s0, vecs[i].s1, i == 0, 1'b0);
            if (i == 0) begin
                @(negedge clk);
                check("valid_at_T4", {127'd0, ct_valid}, 128'd1);
                tick();
                @(negedge clk);
                check("valid_at_T5", {127'd0, ct_valid}, 128'd0);
                tick();
            end
        end
        tick();
        tick();
        @(negedge clk);
        check("table_valid_idle", {127'd0, ct_valid}, 128'd0);
        check("table_sb_empty", 128'(sb.size()), 128'd0);
        tick();

        // Back-pressure: second block is dropped, first held.
        ct_ready = 1'b0;
        sb.push_back(vecs[1]);
        send_block(vecs[1].s0, vecs[1].s1, 1'b0, 1'b0);
        send_block(vecs[3].s0, vecs[3].s1, 1'b0, 1'b0);
        @(negedge clk);
        check("bp_valid",    {127'd0, ct_valid}, 128'd1);
        check("bp_held_s0",  ct_share0, vecs[1].s0);
        check("bp_held_dat", ct_data,   c_CT);
        check("bp_overflow", {127'd0, overflow}, 128'd1);
        check("bp_drop_cnt", {120'd0, drop_cnt}, 128'd1);
        hs_base = hs_count;
        tick();
        ct_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("bp_one_hs", 128'(hs_count - hs_base), 128'd1);
        check("bp_valid_after", {127'd0, ct_valid}, 128'd0);
        tick();

        // Simultaneous accept and refill.
        do_reset();
        ct_ready = 1'b0;
        sb.push_back(vecs[2]);
        sb.push_back(vecs[3]);
        send_block(vecs[2].s0, vecs[2].s1, 1'b0, 1'b0);
        send_block(vecs[3].s0, vecs[3].s1, 1'b0, 1'b1);
        @(negedge clk);
        check("sim_valid",    {127'd0, ct_valid}, 128'd1);
        check("sim_data",     ct_data, vecs[3].data);
        check("sim_share0",   ct_share0, vecs[3].s0);
        check("sim_drop",     {120'd0, drop_cnt}, 128'd0);
        check("sim_overflow", {127'd0, overflow}, 128'd0);
        ct_ready = 1'b1;
        tick();
        tick();
        tick();
        @(negedge clk);
        check("sim_valid_after", {127'd0, ct_valid}, 128'd0);
        check("sim_sb_empty", 128'(sb.size()), 128'd0);
        tick();

        // Framing: done rises again two cycles into a capture.
        do_reset();
        ct_ready = 1'b1;
        sb.push_back(vecs[3]);
        for (int k = 0; k < 6; k++) begin
            done = (k == 0) || (k == 2);
            if (k < 2) begin
                OutputData0 = 32'hdeaddead;
                OutputData1 = 32'h0badf00d;
            end else begin
                OutputData0 = vecs[3].s0[127 - 32*(k-2) -: 32];
                OutputData1 = vecs[3].s1[127 - 32*(k-2) -: 32];
            end
            if (k >= 3) begin
                @(negedge clk);
                check("frame_no_early_valid", {127'd0, ct_valid}, 128'd0);
            end
            tick();
        end
        done = 1'b0;
        OutputData0 = '0;
        OutputData1 = '0;
        @(negedge clk);
        check("frame_valid_T6", {127'd0, ct_valid}, 128'd1);
        check("frame_err_set",  {127'd0, frame_err}, 128'd1);
        tick();
        tick();

        // Reset asserted one cycle into a capture.
        done = 1'b1;
        OutputData0 = vecs[0].s0[127:96];
        OutputData1 = 32'h0;
        tick();
        done = 1'b0;
        rst = 1'b1;
        OutputData0 = vecs[0].s0[95:64];
        tick();
        rst = 1'b0;
        OutputData0 = vecs[0].s0[63:32];
        tick();
        OutputData0 = vecs[0].s0[31:0];
        tick();
        OutputData0 = '0;
        for (int k = 0; k < 5; k++) tick();
        @(negedge clk);
        check("rstcap_valid",    {127'd0, ct_valid},  128'd0);
        check("rstcap_frame",    {127'd0, frame_err}, 128'd0);
        check("rstcap_overflow", {127'd0, overflow},  128'd0);
        check("rstcap_drop",     {120'd0, drop_cnt},  128'd0);
        check("rstcap_data",     ct_data, 128'd0);
        tick();

        // done held high through reset release must not start a capture.
        rst = 1'b1;
        done = 1'b1;
        OutputData0 = 32'h11111111;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        done = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        @(negedge clk);
        check("held_done_no_valid", {127'd0, ct_valid}, 128'd0);
        tick();
        OutputData0 = '0;
        sb.push_back(vecs[1]);
        send_block(vecs[1].s0, vecs[1].s1, 1'b0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        check("final_sb_empty", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
